codificador_4_2_fila: RTL

Registered 4-to-2 encoder with event capture: the counterpart of the 2-to-4 decoder (Y0..Y3 → A,B). It detects rising edges on four request lines and stores them as pending events. It encodes the highest-priority pending event into a 2-bit code and delivers it over a valid/ready handshake. It sits between one-hot event sources (buttons, decoder outputs, interrupt lines) and a consumer that expects binary indices.

---
 rtl/codificador_pkg.sv | 20 ++
 rtl/codificador_prioridade_4_2.sv | 24 ++
 rtl/codificador_4_2_fila.sv | 119 +++++++++++
 3 files changed

// File: rtl/codificador_pkg.sv
// Shared definitions for the 4-to-2 event encoder: widths, FSM states and
// a small helper that turns a code back into its one-hot request bit.
package codificador_pkg;

  localparam int N_REQ  = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  // One-hot mask of the request bit addressed by a code (2-to-4 decode).
  function automatic logic [N_REQ-1:0] code_onehot(input logic [CODE_W-1:0] c);
    logic [N_REQ-1:0] mask;
    mask = 4'b0001 << c;
    return mask;
  endfunction

endpackage

// File: rtl/codificador_prioridade_4_2.sv
// Combinational 4-to-2 priority encoder: bit 3 has the highest priority.
// any flags that at least one input bit is set; idx is 0 when none is.
module codificador_prioridade_4_2
  import codificador_pkg::*;
(
  input  logic [N_REQ-1:0]  in,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Select the index of the highest set bit.
  always_comb begin
    idx = 2'b00;
    any = 1'b0;
    casez (in)
      4'b1???: begin idx = 2'b11; any = 1'b1; end
      4'b01??: begin idx = 2'b10; any = 1'b1; end
      4'b001?: begin idx = 2'b01; any = 1'b1; end
      4'b0001: begin idx = 2'b00; any = 1'b1; end
      default: begin idx = 2'b00; any = 1'b0; end
    endcase
  end

endmodule

// File: rtl/codificador_4_2_fila.sv
// Registered 4-to-2 encoder with event capture. Rising edges on req are
// latched into pend; the highest-priority pending event is presented as a
// binary code over a valid/ready handshake. All outputs are registered.
module codificador_4_2_fila
  import codificador_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_REQ-1:0]  req,
  input  logic              ready,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [N_REQ-1:0]  pend,
  output logic              ovf
);

  state_t            state_r;
  state_t            state_next_s;
  logic [N_REQ-1:0]  req_q_r;
  logic [N_REQ-1:0]  rise_s;
  logic [N_REQ-1:0]  rise_en_s;
  logic [N_REQ-1:0]  clr_s;
  logic [N_REQ-1:0]  pend_next_s;
  logic              ovf_next_s;
  logic [N_REQ-1:0]  sel_s;
  logic [CODE_W-1:0] sel_idx_s;
  logic              sel_any_s;
  logic [CODE_W-1:0] code_next_s;
  logic              valid_next_s;

  // Edge detection, acceptance clear mask, pending update and overflow flag.
  always_comb begin
    rise_s    = req & ~req_q_r;
    rise_en_s = en ? rise_s : 4'b0000;
    // valid is only high in SHOW, so this is the accepted code's bit or 0.
    if (valid && ready) begin
      clr_s = code_onehot(code);
    end else begin
      clr_s = 4'b0000;
    end
    // A rise on the bit being cleared re-arms it rather than overflowing.
    pend_next_s = (pend & ~clr_s) | rise_en_s;
    ovf_next_s  = |(rise_en_s & pend & ~clr_s);
    // From IDLE only already-registered events are served; from SHOW the
    // post-acceptance set (including this cycle's rises) feeds the next code.
    if (state_r == ST_IDLE) begin
      sel_s = pend;
    end else begin
      sel_s = pend_next_s;
    end
  end

  codificador_prioridade_4_2 u_prioridade (
    .in  (sel_s),
    .idx (sel_idx_s),
    .any (sel_any_s)
  );

  // Next-state and next-output logic of the presentation FSM.
  always_comb begin
    state_next_s = state_r;
    code_next_s  = code;
    valid_next_s = valid;
    case (state_r)
      ST_IDLE: begin
        if (sel_any_s) begin
          code_next_s  = sel_idx_s;
          valid_next_s = 1'b1;
          state_next_s = ST_SHOW;
        end else begin
          valid_next_s = 1'b0;
          state_next_s = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (ready) begin
          if (sel_any_s) begin
            code_next_s  = sel_idx_s;
            valid_next_s = 1'b1;
            state_next_s = ST_SHOW;
          end else begin
            valid_next_s = 1'b0;
            state_next_s = ST_IDLE;
          end
        end else begin
          // Hold code stable until accepted, even if higher priority arrives.
          valid_next_s = 1'b1;
          state_next_s = ST_SHOW;
        end
      end
      default: begin
        code_next_s  = 2'b00;
        valid_next_s = 1'b0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      req_q_r <= 4'b0000;
      pend    <= 4'b0000;
      code    <= 2'b00;
      valid   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      req_q_r <= req;
      pend    <= pend_next_s;
      code    <= code_next_s;
      valid   <= valid_next_s;
      ovf     <= ovf_next_s;
    end
  end

endmodule
